snake_engine: RTL and testbench
===============================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning playfield width in cells.
REQ-002 SHALL have parameter GRID_H, default 30, meaning playfield height in cells.
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning body segment capacity, with legal range 4..64.
REQ-004 SHALL have parameters START_X, default 20, and START_Y, default 15, meaning the head cell at reset.
REQ-005 SHALL have port clk, input, width 1: the single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port game_tick, input, width 1: one-cycle move-request pulse from the tick divider.
REQ-008 SHALL have port dir_in, input, width 2: requested direction, encoded 0=up, 1=right, 2=down, 3=left.
REQ-009 SHALL have ports food_x, input, width 6, and food_y, input, width 5: current food cell.
REQ-010 SHALL have ports query_x, input, width 6, and query_y, input, width 5: renderer cell lookup.
REQ-011 SHALL have ports head_x, output, width 6, and head_y, output, width 5: the registered head cell.
REQ-012 SHALL have port length, output, width 7: current segment count.
REQ-013 SHALL have port query_hit, output, width 1: registered, high when the query cell is occupied by any live segment.
REQ-014 SHALL have port ate, output, width 1: one-cycle pulse when food is consumed.
REQ-015 SHALL have port move_done, output, width 1: one-cycle pulse when a move commits.
REQ-016 SHALL have port game_over, output, width 1: sticky collision flag.

Function
REQ-017 SHALL store segments in arrays seg_x/seg_y[0..MAX_LEN-1], with index 0 as the head; only indices < length are live.
REQ-018 SHALL implement states IDLE, CALC, SCAN, COMMIT and DEAD.
REQ-019 SHALL, in IDLE on game_tick=1, latch dir_in into cur_dir unless dir_in is the 180-degree reverse of cur_dir (then keep cur_dir), and go to CALC.
REQ-020 SHALL, in CALC, compute next head = head +/- 1 on one axis per cur_dir; an underflow below 0 or a value >= GRID_W/GRID_H sets wall_hit; then go to SCAN.
REQ-021 SHALL, in CALC, set grow when next head == (food_x, food_y) and length < MAX_LEN; food eaten at length == MAX_LEN moves normally, without growth, and still pulses ate.
REQ-022 SHALL, in SCAN, compare the next head against one segment per cycle, index 0 upward, through index length-2 when grow=0 (the tail vacates) or length-1 when grow=1.
REQ-023 SHALL exit SCAN early to DEAD on a match or when wall_hit=1, otherwise go to COMMIT after the last index.
REQ-024 SHALL, in COMMIT, shift seg[i] <= seg[i-1] for all i >= 1 and load seg[0] <= next head; increment length if grow=1; pulse move_done (and ate if food matched); return to IDLE.
REQ-025 SHALL ignore game_tick in any state other than IDLE; requests are dropped, not queued.
REQ-026 SHALL, in DEAD, hold game_over=1 and freeze all segments until reset; game_tick has no effect.
REQ-027 SHALL register query_hit one cycle after query_x/query_y using a parallel compare over live segments; this path is independent of the FSM state.
REQ-028 SHALL hold head_x/head_y equal to seg_x[0]/seg_y[0]; they change only in COMMIT.
REQ-029 SHALL have a worst-case move latency from game_tick to move_done of length+2 cycles, at most MAX_LEN+2.

Reset
REQ-030 SHALL, on reset_n=0 at any time including mid-SCAN, immediately enter IDLE.
REQ-031 SHALL set cur_dir=right and length=3 on reset.
REQ-032 SHALL set seg[i] = (START_X-i, START_Y) for i < 3 and all other segments to 0 on reset.
REQ-033 SHALL clear query_hit, ate, move_done and game_over to 0 on reset.
REQ-034 SHALL resume operation on the first rising clk edge after reset_n rises.

Verification
REQ-035 SHALL cover: after reset, one tick with dir_in=1 -> head (21,15), length 3, move_done within 5 cycles, tail cell (18,15) no longer hits.
REQ-036 SHALL cover: at reset with cur_dir=right, tick with dir_in=3 (reverse) -> ignored, head moves to (21,15).
REQ-037 SHALL cover: food at (21,15), one tick -> ate pulse, length 4, segments (21..18,15).
REQ-038 SHALL cover: head driven to x=39 heading right, next tick -> game_over=1, head stays at 39, later ticks ignored.
REQ-039 SHALL cover: length 5 steered into a U-turn (up, left, down) into its own body -> game_over=1; reset_n pulse mid-SCAN -> length 3 and head (20,15).
REQ-040 SHALL cover: length at MAX_LEN eating food -> ate pulses, length unchanged; game_tick asserted during SCAN -> exactly one move.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: grid-based snake movement core.
// A move request walks IDLE -> CALC -> SCAN -> COMMIT. The self-collision
// scan is serial, one segment per cycle. A renderer lookup port is answered
// by a parallel compare over the live segments. Any wall or body collision
// parks the engine in DEAD until reset.
module snake_engine #(
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MAX_LEN = 16,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_tick,
  input  logic [1:0] dir_in,
  input  logic [5:0] food_x,
  input  logic [4:0] food_y,
  input  logic [5:0] query_x,
  input  logic [4:0] query_y,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [6:0] length,
  output logic       query_hit,
  output logic       ate,
  output logic       move_done,
  output logic       game_over
);

  localparam int         IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] LP_GRID_W   = 7'(GRID_W);
  localparam logic [6:0] LP_GRID_H   = 7'(GRID_H);
  localparam logic [6:0] LP_MAX_LEN  = 7'(MAX_LEN);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [5:0] r_seg_x [0:MAX_LEN-1];
  logic [4:0] r_seg_y [0:MAX_LEN-1];
  logic [6:0] r_len;
  logic [1:0] r_dir;

  // Move context captured in CALC and consumed by SCAN/COMMIT.
  logic [5:0] r_nx;
  logic [4:0] r_ny;
  logic       r_wall;
  logic       r_grow;
  logic       r_food;
  logic [6:0] r_idx;
  logic [6:0] r_last;

  logic       r_move_done;
  logic       r_ate;
  logic       r_game_over;
  logic       r_query_hit;

  logic [5:0] w_nx;
  logic [4:0] w_ny;
  logic       w_wall;
  logic       w_food;
  logic       w_grow;
  logic       w_scan_match;
  logic       w_query_hit;
  logic [1:0] w_dir_reverse;

  assign w_dir_reverse = r_dir ^ 2'b10;

  // Next-head arithmetic from the current head and direction; wall_hit flags leaving the grid.
  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (r_dir)
      DIR_UP: begin
        if (r_seg_y[0] == 5'd0) begin
          w_wall = 1'b1;
        end else begin
          w_ny = r_seg_y[0] - 5'd1;
        end
      end
      DIR_RIGHT: begin
        if (({1'b0, r_seg_x[0]} + 7'd1) >= LP_GRID_W) begin
          w_wall = 1'b1;
        end else begin
          w_nx = r_seg_x[0] + 6'd1;
        end
      end
      DIR_DOWN: begin
        if (({2'b00, r_seg_y[0]} + 7'd1) >= LP_GRID_H) begin
          w_wall = 1'b1;
        end else begin
          w_ny = r_seg_y[0] + 5'd1;
        end
      end
      DIR_LEFT: begin
        if (r_seg_x[0] == 6'd0) begin
          w_wall = 1'b1;
        end else begin
          w_nx = r_seg_x[0] - 6'd1;
        end
      end
      default: begin
        w_wall = 1'b0;
      end
    endcase
    w_food = (w_nx == food_x) && (w_ny == food_y);
    w_grow = w_food && (r_len < LP_MAX_LEN);
  end

  // The serial scan compares the latched next head with one segment per cycle.
  assign w_scan_match = (r_seg_x[r_idx[IW-1:0]] == r_nx) &&
                        (r_seg_y[r_idx[IW-1:0]] == r_ny);

  // Renderer lookup: compare the query cell against every live segment at once.
  always_comb begin
    w_query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_query_hit = w_query_hit |
                    ((7'(i) < r_len) && (r_seg_x[i] == query_x) && (r_seg_y[i] == query_y));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; ticks outside IDLE are simply not looked at.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (game_tick) begin
          w_state_next = ST_CALC;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CALC: begin
        w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (r_wall || w_scan_match) begin
          w_state_next = ST_DEAD;
        end else if (r_idx == r_last) begin
          w_state_next = ST_COMMIT;
        end else begin
          w_state_next = ST_SCAN;
        end
      end
      ST_COMMIT: begin
        w_state_next = ST_IDLE;
      end
      ST_DEAD: begin
        w_state_next = ST_DEAD;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Body, length, direction and move-context datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < 3) begin
          r_seg_x[i] <= 6'(START_X - i);
          r_seg_y[i] <= 5'(START_Y);
        end else begin
          r_seg_x[i] <= 6'd0;
          r_seg_y[i] <= 5'd0;
        end
      end
      r_len  <= 7'd3;
      r_dir  <= DIR_RIGHT;
      r_nx   <= 6'd0;
      r_ny   <= 5'd0;
      r_wall <= 1'b0;
      r_grow <= 1'b0;
      r_food <= 1'b0;
      r_idx  <= 7'd0;
      r_last <= 7'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A reversal request would fold the snake onto its neck, so it is discarded.
          if (game_tick && (dir_in != w_dir_reverse)) begin
            r_dir <= dir_in;
          end
        end
        ST_CALC: begin
          r_nx   <= w_nx;
          r_ny   <= w_ny;
          r_wall <= w_wall;
          r_grow <= w_grow;
          r_food <= w_food;
          r_idx  <= 7'd0;
          // Without growth the tail cell vacates during this move, so it is not scanned.
          r_last <= w_grow ? (r_len - 7'd1) : (r_len - 7'd2);
        end
        ST_SCAN: begin
          r_idx <= r_idx + 7'd1;
        end
        ST_COMMIT: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= r_nx;
          r_seg_y[0] <= r_ny;
          if (r_grow) begin
            r_len <= r_len + 7'd1;
          end
        end
        default: begin
          r_len <= r_len;
        end
      endcase
    end
  end

  // Status pulses, the sticky collision flag and the registered lookup result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_move_done <= 1'b0;
      r_ate       <= 1'b0;
      r_game_over <= 1'b0;
      r_query_hit <= 1'b0;
    end else begin
      r_move_done <= (r_state == ST_COMMIT);
      r_ate       <= (r_state == ST_COMMIT) && r_food;
      r_game_over <= r_game_over | (w_state_next == ST_DEAD);
      r_query_hit <= w_query_hit;
    end
  end

  assign head_x    = r_seg_x[0];
  assign head_y    = r_seg_y[0];
  assign length    = r_len;
  assign query_hit = r_query_hit;
  assign ate       = r_ate;
  assign move_done = r_move_done;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_engine.sv
// Directed testbench for snake_engine with default parameters (40x30 grid, 16 segments).
module tb_snake_engine;

  logic       clk;
  logic       reset_n;
  logic       game_tick;
  logic [1:0] dir_in;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic [5:0] query_x;
  logic [4:0] query_y;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [6:0] length;
  logic       query_hit;
  logic       ate;
  logic       move_done;
  logic       game_over;

  int tests_run = 0;
  int tests_failed = 0;

  snake_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .game_tick (game_tick),
    .dir_in    (dir_in),
    .food_x    (food_x),
    .food_y    (food_y),
    .query_x   (query_x),
    .query_y   (query_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .query_hit (query_hit),
    .ate       (ate),
    .move_done (move_done),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    game_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle tick pulse; returns at the negedge after the sampling posedge.
  task automatic tick(input logic [1:0] d);
    @(negedge clk);
    game_tick = 1'b1;
    dir_in    = d;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  // Waits (bounded) for move_done or game_over; cyc counts edges after the tick edge.
  task automatic wait_evt(input int max_cyc, output int cyc, output logic saw_done, output logic saw_ate);
    cyc = 0;
    saw_done = 1'b0;
    saw_ate = 1'b0;
    while ((cyc < max_cyc) && !saw_done && (game_over !== 1'b1)) begin
      @(negedge clk);
      cyc++;
      if (move_done === 1'b1) begin
        saw_done = 1'b1;
        saw_ate  = ate;
      end
    end
  endtask

  task automatic do_query(input logic [5:0] x, input logic [4:0] y, output logic hit);
    @(negedge clk);
    query_x = x;
    query_y = y;
    @(negedge clk);
    hit = query_hit;
  endtask

  task automatic test_reset();
    logic h;
    do_reset();
    tests_run++;
    if (head_x !== 6'd20 || head_y !== 5'd15) begin
      tests_failed++;
      $display("FAIL reset_head: got (%0d,%0d) expected (20,15)", head_x, head_y);
    end
    tests_run++;
    if (length !== 7'd3 || game_over !== 1'b0 || move_done !== 1'b0 || ate !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: len=%0d go=%b md=%b ate=%b expected 3,0,0,0", length, game_over, move_done, ate);
    end
    do_query(6'd18, 5'd15, h);
    tests_run++;
    if (h !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_query_tail: got %b expected 1", h);
    end
    do_query(6'd17, 5'd15, h);
    tests_run++;
    if (h !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_query_empty: got %b expected 0", h);
    end
  endtask

  task automatic test_move();
    int cyc;
    logic d, a, h;
    do_reset();
    tick(2'd1);
    wait_evt(10, cyc, d, a);
    tests_run++;
    if (d !== 1'b1 || cyc > 5) begin
      tests_failed++;
      $display("FAIL move_latency: done=%b cycles=%0d expected done within 5", d, cyc);
    end
    tests_run++;
    if (head_x !== 6'd21 || head_y !== 5'd15 || length !== 7'd3 || a !== 1'b0) begin
      tests_failed++;
      $display("FAIL move_head: got (%0d,%0d) len=%0d ate=%b expected (21,15) 3 0", head_x, head_y, length, a);
    end
    do_query(6'd18, 5'd15, h);
    tests_run++;
    if (h !== 1'b0) begin
      tests_failed++;
      $display("FAIL move_tail_vacated: got %b expected 0", h);
    end
  endtask

  task automatic test_reverse();
    int cyc;
    logic d, a;
    do_reset();
    tick(2'd3);
    wait_evt(10, cyc, d, a);
    tests_run++;
    if (d !== 1'b1 || head_x !== 6'd21 || head_y !== 5'd15) begin
      tests_failed++;
      $display("FAIL reverse_ignored: done=%b head (%0d,%0d) expected 1 (21,15)", d, head_x, head_y);
    end
  endtask

  task automatic test_eat();
    int cyc;
    logic d, a, h;
    do_reset();
    food_x = 6'd21;
    food_y = 5'd15;
    tick(2'd1);
    wait_evt(10, cyc, d, a);
    food_x = 6'd0;
    food_y = 5'd0;
    tests_run++;
    if (d !== 1'b1 || a !== 1'b1 || cyc > 5) begin
      tests_failed++;
      $display("FAIL eat_pulse: done=%b ate=%b cycles=%0d expected 1 1 <=5", d, a, cyc);
    end
    tests_run++;
    if (length !== 7'd4 || head_x !== 6'd21) begin
      tests_failed++;
      $display("FAIL eat_length: len=%0d head_x=%0d expected 4 21", length, head_x);
    end
    do_query(6'd18, 5'd15, h);
    tests_run++;
    if (h !== 1'b1) begin
      tests_failed++;
      $display("FAIL eat_tail_kept: got %b expected 1", h);
    end
    do_query(6'd17, 5'd15, h);
    tests_run++;
    if (h !== 1'b0) begin
      tests_failed++;
      $display("FAIL eat_beyond_tail: got %b expected 0", h);
    end
  endtask

  task automatic test_wall();
    int cyc;
    logic d, a;
    do_reset();
    for (int k = 0; k < 19; k++) begin
      tick(2'd1);
      wait_evt(10, cyc, d, a);
    end
    tests_run++;
    if (head_x !== 6'd39 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL wall_approach: head_x=%0d go=%b expected 39 0", head_x, game_over);
    end
    tick(2'd1);
    wait_evt(10, cyc, d, a);
    tests_run++;
    if (game_over !== 1'b1 || d !== 1'b0 || head_x !== 6'd39) begin
      tests_failed++;
      $display("FAIL wall_hit: go=%b done=%b head_x=%0d expected 1 0 39", game_over, d, head_x);
    end
    tick(2'd0);
    d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      d = d | move_done;
    end
    tests_run++;
    if (game_over !== 1'b1 || d !== 1'b0 || head_x !== 6'd39 || head_y !== 5'd15 || length !== 7'd3) begin
      tests_failed++;
      $display("FAIL dead_frozen: go=%b done=%b head (%0d,%0d) len=%0d expected 1 0 (39,15) 3",
               game_over, d, head_x, head_y, length);
    end
  endtask

  task automatic test_uturn();
    int cyc;
    logic d, a;
    do_reset();
    food_x = 6'd21; food_y = 5'd15;
    tick(2'd1); wait_evt(10, cyc, d, a);
    food_x = 6'd22; food_y = 5'd15;
    tick(2'd1); wait_evt(10, cyc, d, a);
    food_x = 6'd0; food_y = 5'd0;
    tests_run++;
    if (length !== 7'd5 || head_x !== 6'd22) begin
      tests_failed++;
      $display("FAIL uturn_grow: len=%0d head_x=%0d expected 5 22", length, head_x);
    end
    tick(2'd0); wait_evt(10, cyc, d, a);
    tick(2'd3); wait_evt(10, cyc, d, a);
    tests_run++;
    if (head_x !== 6'd21 || head_y !== 5'd14 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL uturn_path: head (%0d,%0d) go=%b expected (21,14) 0", head_x, head_y, game_over);
    end
    tick(2'd2); wait_evt(10, cyc, d, a);
    tests_run++;
    if (game_over !== 1'b1 || d !== 1'b0 || head_x !== 6'd21 || head_y !== 5'd14) begin
      tests_failed++;
      $display("FAIL uturn_collide: go=%b done=%b head (%0d,%0d) expected 1 0 (21,14)", game_over, d, head_x, head_y);
    end
    // Rebuild length 5, then pull reset while the scan is in flight.
    do_reset();
    food_x = 6'd21; food_y = 5'd15;
    tick(2'd1); wait_evt(10, cyc, d, a);
    food_x = 6'd22; food_y = 5'd15;
    tick(2'd1); wait_evt(10, cyc, d, a);
    food_x = 6'd0; food_y = 5'd0;
    tick(2'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (length !== 7'd3 || head_x !== 6'd20 || head_y !== 5'd15 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_scan: len=%0d head (%0d,%0d) go=%b expected 3 (20,15) 0", length, head_x, head_y, game_over);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(2'd1); wait_evt(10, cyc, d, a);
    tests_run++;
    if (d !== 1'b1 || head_x !== 6'd21 || length !== 7'd3) begin
      tests_failed++;
      $display("FAIL resume_after_reset: done=%b head_x=%0d len=%0d expected 1 21 3", d, head_x, length);
    end
  endtask

  task automatic test_max_len();
    int cyc;
    logic d, a, h;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      food_x = 6'(20 + k);
      food_y = 5'd15;
      tick(2'd1);
      wait_evt(20, cyc, d, a);
      tests_run++;
      if (length !== 7'(3 + k) || a !== 1'b1) begin
        tests_failed++;
        $display("FAIL grow_step%0d: len=%0d ate=%b expected %0d 1", k, length, a, 3 + k);
      end
    end
    food_x = 6'd34;
    food_y = 5'd15;
    tick(2'd1);
    wait_evt(20, cyc, d, a);
    food_x = 6'd0;
    food_y = 5'd0;
    tests_run++;
    if (d !== 1'b1 || a !== 1'b1 || length !== 7'd16 || head_x !== 6'd34 || cyc > 18) begin
      tests_failed++;
      $display("FAIL full_eat: done=%b ate=%b len=%0d head_x=%0d cycles=%0d expected 1 1 16 34 <=18",
               d, a, length, head_x, cyc);
    end
    do_query(6'd19, 5'd15, h);
    tests_run++;
    if (h !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_tail: got %b expected 1", h);
    end
    do_query(6'd18, 5'd15, h);
    tests_run++;
    if (h !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_beyond_tail: got %b expected 0", h);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    do_reset();
    tick(2'd1);
    @(negedge clk);
    game_tick = 1'b1;
    dir_in    = 2'd0;
    @(negedge clk);
    game_tick = 1'b0;
    pulses = (move_done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (move_done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 1 || head_x !== 6'd21 || head_y !== 5'd15) begin
      tests_failed++;
      $display("FAIL tick_during_scan: pulses=%0d head (%0d,%0d) expected 1 (21,15)", pulses, head_x, head_y);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    game_tick = 1'b0;
    dir_in    = 2'd1;
    food_x    = 6'd0;
    food_y    = 5'd0;
    query_x   = 6'd0;
    query_y   = 5'd0;
    test_reset();
    test_move();
    test_reverse();
    test_eat();
    test_wall();
    test_uturn();
    test_max_len();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
